arcade_input_cond: RTL and testbench

Input conditioner between the merged joystick/DB9/DB15 player words and the `burnin_rubber` game core, all on `clk_sys`. Each bit is synchronised and debounced. Each coin bit is shaped into a fixed-length, vblank-timed pulse so the game's coin handler always sees a legal coin-switch waveform. All inputs are masked while the pause system holds the CPU. A wrapping coin-event counter is provided for diagnostics.

---
 rtl/arcade_input_cond.sv | 174 +++++++++++++++++
 tb/tb_arcade_input_cond.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// Player-input conditioner: 2-FF sync + per-bit debounce, vblank-timed coin
// pulse shaping per player, pause masking and a wrapping coin-event counter.

module arcade_input_cond_deb #(
  parameter int DEB_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The edge that would take the count to DEB_CYCLES commits the new value.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = s2_q;
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
endmodule

module arcade_input_cond_coin #(
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic c,
  input  logic vb_rise,
  input  logic paused,
  output logic start,
  output logic pulse
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, RELEASE} state_t;

  localparam logic [3:0] FRAMES = 4'(COIN_FRAMES);
  localparam logic [3:0] GAPF   = 4'(COIN_GAP_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] frm_q, frm_d;
  logic       pulse_q, pulse_d;

  // Pause freezes state and frame count so an interrupted pulse resumes.
  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    start   = 1'b0;
    if (!paused) begin
      case (state_q)
        IDLE: if (c) begin
          state_d = PULSE;
          frm_d   = FRAMES;
          start   = 1'b1;
        end
        PULSE: if (vb_rise) begin
          if (frm_q == 4'd1) begin
            frm_d   = GAPF;
            state_d = (COIN_GAP_FRAMES == 0) ? RELEASE : GAP;
          end else begin
            frm_d = frm_q - 4'd1;
          end
        end
        GAP: if (vb_rise) begin
          frm_d = frm_q - 4'd1;
          if (frm_q == 4'd1) state_d = RELEASE;
        end
        RELEASE: if (!c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    pulse_d = (state_d == PULSE) && !paused;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frm_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

module arcade_input_cond #(
  parameter int DEB_CYCLES      = 12000,
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       paused,
  input  logic [7:0] joy0_in,
  input  logic [7:0] joy1_in,
  output logic [7:0] joy0_out,
  output logic [7:0] joy1_out,
  output logic [7:0] coin_events
);
  localparam int NUM_BITS = 16;

  logic [NUM_BITS-1:0] raw, stable;
  logic [1:0]          coin_c, coin_start, coin_pulse;
  logic [13:0]         out_q, out_d;
  logic [7:0]          coin_events_q, coin_events_d;
  logic                vb_q, vb_rise;

  assign raw = {joy1_in, joy0_in};

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_deb
    arcade_input_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .din(raw[i]), .stable(stable[i]));
  end

  assign coin_c  = {stable[15], stable[7]};
  assign vb_rise = vblank & ~vb_q;

  for (genvar p = 0; p < 2; p++) begin : g_coin
    arcade_input_cond_coin #(
      .COIN_FRAMES(COIN_FRAMES), .COIN_GAP_FRAMES(COIN_GAP_FRAMES)
    ) u_coin (
      .clk(clk), .reset(reset), .c(coin_c[p]), .vb_rise(vb_rise),
      .paused(paused), .start(coin_start[p]), .pulse(coin_pulse[p]));
  end

  always_comb begin
    out_d         = {stable[14:8], stable[6:0]} & {14{~paused}};
    coin_events_d = coin_events_q + 8'(coin_start[0]) + 8'(coin_start[1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q          <= 1'b0;
      out_q         <= '0;
      coin_events_q <= '0;
    end else begin
      vb_q          <= vblank;
      out_q         <= out_d;
      coin_events_q <= coin_events_d;
    end
  end

  assign joy0_out    = {coin_pulse[0], out_q[6:0]};
  assign joy1_out    = {coin_pulse[1], out_q[13:7]};
  assign coin_events = coin_events_q;
endmodule

// File: tb/tb_arcade_input_cond.sv
// Scoreboard bench for arcade_input_cond: expected coin-pulse starts and
// event counts are queued at stimulus time and checked as pulses appear.

module tb_arcade_input_cond;
  localparam int DEB = 4, CF = 3, CG = 2;

  logic       clk = 1'b0, reset = 1'b0, vblank = 1'b0, paused = 1'b0;
  logic [7:0] joy0_in = '0, joy1_in = '0;
  logic [7:0] joy0_out, joy1_out, coin_events;

  int         cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] exp_ev = '0;

  typedef struct { int cyc; logic [7:0] ev; } exp_t;
  exp_t exp_q[$];

  arcade_input_cond #(.DEB_CYCLES(DEB), .COIN_FRAMES(CF), .COIN_GAP_FRAMES(CG)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .paused(paused),
    .joy0_in(joy0_in), .joy1_in(joy1_in), .joy0_out(joy0_out),
    .joy1_out(joy1_out), .coin_events(coin_events));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // vblank rises at the negedge where cyc is a multiple of 100
  always @(negedge clk) vblank = (cyc % 100) < 10;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic coin(input int p);
    return (p == 0) ? joy0_out[7] : joy1_out[7];
  endfunction

  // Pulse falls on the edge after the 3rd vblank rise at or after start.
  function automatic int fall_at(input int s);
    return ((s + 99) / 100) * 100 + (CF - 1) * 100 + 1;
  endfunction

  task automatic push_exp(input int c, input logic [7:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int p, input logic lvl, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (coin(p) === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if ({joy0_out, joy1_out} !== 16'h0) begin
      n_fail++; $display("FAIL reset_outs: got %h required 0000", {joy0_out, joy1_out});
    end
    n_chk++;
    if (coin_events !== 8'd0) begin
      n_fail++; $display("FAIL reset_events: got %0d required 0", coin_events);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++;
    if ({joy0_out, joy1_out, coin_events} !== 24'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h required 0", {joy0_out, joy1_out, coin_events});
    end
  endtask

  task automatic test_debounce;
    int d, bad, seen;
    @(negedge clk); joy0_in[4] = 1'b1; d = cyc;
    repeat (6) @(negedge clk);
    n_chk++;
    if (joy0_out[4] !== 1'b0) begin
      n_fail++; $display("FAIL deb_early: at cyc %0d got %b required 0", cyc - d, joy0_out[4]);
    end
    @(negedge clk);
    n_chk++;
    if (joy0_out[4] !== 1'b1) begin
      n_fail++; $display("FAIL deb_latency: at cyc %0d got %b required 1", cyc - d, joy0_out[4]);
    end
    // DEB-1 clock glitch must be rejected
    bad = 0;
    joy0_in[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) joy0_in[0] = 1'b0;
      if (joy0_out[0] !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL glitch_reject: got %0d high cycles required 0", bad);
    end
    // exactly DEB clocks of stability is accepted
    seen = 0;
    joy0_in[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) joy0_in[1] = 1'b0;
      if (joy0_out[1] === 1'b1) seen = 1;
    end
    n_chk++;
    if (seen != 1) begin
      n_fail++; $display("FAIL deb_exact: got %0d required 1", seen);
    end
    joy0_in[4] = 1'b0; d = cyc;
    repeat (7) @(negedge clk);
    n_chk++;
    if (joy0_out[4] !== 1'b0) begin
      n_fail++; $display("FAIL deb_fall: got %b required 0", joy0_out[4]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_held_coin;
    int at, f, extra;
    logic prev;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); joy0_in[7] = 1'b1; exp_ev++; push_exp(cyc + DEB + 3, exp_ev);
      wait_edge(0, 1'b1, 40, at);
      e = exp_q.pop_front();
      n_chk++;
      if (at != e.cyc || coin_events !== e.ev) begin
        n_fail++; $display("FAIL held_start%0d: got cyc %0d ev %0d required cyc %0d ev %0d",
                           k, at, coin_events, e.cyc, e.ev);
      end
      wait_edge(0, 1'b0, 400, f);
      n_chk++;
      if (f != fall_at(e.cyc)) begin
        n_fail++; $display("FAIL held_len%0d: got fall %0d required %0d", k, f, fall_at(e.cyc));
      end
      if (k == 0) begin
        extra = 0; prev = 1'b0;
        for (int i = 0; i < 1700; i++) begin
          @(negedge clk);
          if (joy0_out[7] === 1'b1 && prev === 1'b0) extra++;
          prev = joy0_out[7];
        end
        n_chk++;
        if (extra != 0 || coin_events !== exp_ev) begin
          n_fail++; $display("FAIL held_single: got %0d extra pulses ev %0d required 0 ev %0d",
                             extra, coin_events, exp_ev);
        end
        joy0_in[7] = 1'b0;
        repeat (20) @(negedge clk);
      end
    end
    joy0_in[7] = 1'b0;
    repeat (260) @(negedge clk);
  endtask

  task automatic test_simultaneous;
    int at, f;
    logic [7:0] prev_ev;
    exp_t e;
    @(negedge clk);
    joy0_in[7] = 1'b1; joy1_in[7] = 1'b1;
    exp_ev += 8'd2; push_exp(cyc + DEB + 3, exp_ev);
    at = -1; prev_ev = coin_events;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (joy0_out[7] === 1'b1 || joy1_out[7] === 1'b1) begin
        at = cyc;
        break;
      end
      prev_ev = coin_events;
    end
    e = exp_q.pop_front();
    n_chk++;
    if (at != e.cyc || {joy0_out[7], joy1_out[7]} !== 2'b11) begin
      n_fail++; $display("FAIL simul_start: got cyc %0d coins %b required cyc %0d coins 11",
                         at, {joy0_out[7], joy1_out[7]}, e.cyc);
    end
    n_chk++;
    if (coin_events !== e.ev || prev_ev !== e.ev - 8'd2) begin
      n_fail++; $display("FAIL simul_events: got %0d->%0d required %0d->%0d",
                         prev_ev, coin_events, e.ev - 8'd2, e.ev);
    end
    wait_edge(0, 1'b0, 400, f);
    n_chk++;
    if (f != fall_at(e.cyc) || joy1_out[7] !== 1'b0) begin
      n_fail++; $display("FAIL simul_fall: got %0d p1 %b required %0d p1 0", f, joy1_out[7], fall_at(e.cyc));
    end
    joy0_in[7] = 1'b0; joy1_in[7] = 1'b0;
    repeat (260) @(negedge clk);
  endtask

  task automatic test_pause;
    int at, m, bad, r, f;
    exp_t e;
    @(negedge clk);
    joy0_in[7] = 1'b1; joy0_in[4] = 1'b1; exp_ev++; push_exp(cyc + DEB + 3, exp_ev);
    wait_edge(0, 1'b1, 40, at);
    e = exp_q.pop_front();
    n_chk++;
    if (at != e.cyc || coin_events !== e.ev) begin
      n_fail++; $display("FAIL pause_start: got cyc %0d ev %0d required cyc %0d ev %0d",
                         at, coin_events, e.cyc, e.ev);
    end
    m = ((e.cyc + 99) / 100) * 100;
    for (int i = 0; i < 300 && cyc != m + 1; i++) @(negedge clk);
    n_chk++;
    if (joy0_out[7] !== 1'b1 || joy0_out[4] !== 1'b1) begin
      n_fail++; $display("FAIL pause_pre: got %b required 1xx1xxxx", joy0_out);
    end
    paused = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (joy0_out !== 8'h00) bad++;
    end
    paused = 1'b0;
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL pause_mask: got %0d nonzero cycles required 0", bad);
    end
    wait_edge(0, 1'b1, 10, r);
    n_chk++;
    if (r != m + 502 || joy0_out[4] !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: got cyc %0d bit4 %b required cyc %0d bit4 1",
                         r, joy0_out[4], m + 502);
    end
    wait_edge(0, 1'b0, 400, f);
    n_chk++;
    if (f != m + 701) begin
      n_fail++; $display("FAIL pause_remain: got fall %0d required %0d", f, m + 701);
    end
    joy0_in[7] = 1'b0; joy0_in[4] = 1'b0;
    repeat (260) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int at, f;
    exp_t e;
    @(negedge clk); joy0_in[7] = 1'b1; exp_ev++; push_exp(cyc + DEB + 3, exp_ev);
    wait_edge(0, 1'b1, 40, at);
    e = exp_q.pop_front();
    n_chk++;
    if (at != e.cyc) begin
      n_fail++; $display("FAIL rmid_start: got %0d required %0d", at, e.cyc);
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({joy0_out, joy1_out, coin_events} !== 24'h0) begin
      n_fail++; $display("FAIL rmid_async: got %h required 0", {joy0_out, joy1_out, coin_events});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0; exp_ev = 8'd1; push_exp(cyc + DEB + 3, exp_ev);
    wait_edge(0, 1'b1, 40, at);
    e = exp_q.pop_front();
    n_chk++;
    if (at != e.cyc || coin_events !== e.ev) begin
      n_fail++; $display("FAIL rmid_repress: got cyc %0d ev %0d required cyc %0d ev %0d",
                         at, coin_events, e.cyc, e.ev);
    end
    wait_edge(0, 1'b0, 400, f);
    joy0_in[7] = 1'b0;
    repeat (260) @(negedge clk);
  endtask

  task automatic test_wrap;
    int at;
    exp_t e;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; exp_ev = '0;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk); joy0_in[7] = 1'b1; exp_ev++; push_exp(cyc + DEB + 3, exp_ev);
      @(negedge clk); @(negedge clk);
      joy1_in[7] = 1'b1; exp_ev++; push_exp(cyc + DEB + 3, exp_ev);
      for (int p = 0; p < 2; p++) begin
        wait_edge(p, 1'b1, 20, at);
        e = exp_q.pop_front();
        n_chk++;
        if (at != e.cyc || coin_events !== e.ev) begin
          n_fail++; $display("FAIL wrap_press%0d_p%0d: got cyc %0d ev %0d required cyc %0d ev %0d",
                             n, p, at, coin_events, e.cyc, e.ev);
        end
      end
      joy0_in[7] = 1'b0; joy1_in[7] = 1'b0;
      repeat (510) @(negedge clk);
    end
    n_chk++;
    if (coin_events !== 8'd0) begin
      n_fail++; $display("FAIL wrap_zero: got %0d required 0", coin_events);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_held_coin();
    test_simultaneous();
    test_pause();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
